mem_write_buffer: RTL
=====================

Name: mem_write_buffer

Overview:
- Posted-write buffer between the cache_2wsa memory-side port and main memory, inside the stage1 memory path.
- Cache write-backs complete as soon as they are queued. The buffer drains them to memory in the background, oldest first.
- Cache reads that hit a queued address are forwarded from the buffer. Reads that miss bypass the queue and go to memory ahead of pending writes.
- All buses are unidirectional; the parent handles any tri-state conversion.

Parameters:
AWIDTH, 9, address width (matches cache/memory address bus)
DWIDTH, 8, data width
DEPTH, 4, write entries; power of two, >=2

Ports:
clock  in  1  system clock, shared with cache and memory
reset  in  1  synchronous, active-high reset
addr_c  in  AWIDTH  request address from cache
wdata_c  in  DWIDTH  write data from cache
rd_c  in  1  read request from cache; level, held until ready_c
wr_c  in  1  write request from cache; level, held until ready_c
rdata_c  out  DWIDTH  read data to cache; valid when ready_c=1 for a read
ready_c  out  1  one-cycle completion pulse to cache
addr_m  out  AWIDTH  address to memory
wdata_m  out  DWIDTH  write data to memory
rd_m  out  1  read strobe to memory; held until ready_m
wr_m  out  1  write strobe to memory; held until ready_m
rdata_m  in  DWIDTH  read data from memory; valid with ready_m
ready_m  in  1  memory completion pulse
count  out  $clog2(DEPTH)+1  occupied entries
full  out  1  count==DEPTH
empty  out  1  count==0

Behaviour:
- All outputs are registered. Reset (synchronous, checked at rising edge of clock): FIFO cleared, count=0, empty=1, full=0, ready_c=0, rd_m=0, wr_m=0, addr_m=0, wdata_m=0, rdata_c=0, FSM=IDLE.
- Reset mid-transaction drops the in-flight memory access and all queued writes; no ready_c is issued for the dropped request.
- Cache handshake:
  - The cache raises rd_c or wr_c and holds it, with addr_c/wdata_c stable, until it samples ready_c=1.
  - The cache drops the request the cycle after ready_c.
  - ready_c is high for exactly 1 cycle per request.
  - rd_c and wr_c high together is illegal; rd_c wins.
- Memory handshake:
  - rd_m/wr_m are asserted with stable addr_m/wdata_m until ready_m=1 is sampled.
  - The strobe deasserts on the next edge and stays low for at least 1 cycle between transactions.
- FSM states: IDLE, ACCEPT, DRAIN, RD_MEM, RESP.
- IDLE, evaluated in priority order:
  1. rd_c: the buffer is searched for addr_c.
     - Hit -> RESP with rdata_c = newest matching entry; latency 2 cycles from request to ready_c.
     - Miss -> RD_MEM.
  2. wr_c and !full -> ACCEPT: the entry is written at the tail, count+1, ready_c pulses next cycle.
  3. wr_c and full -> DRAIN; the write stays pending and is accepted on the return to IDLE.
  4. No request and !empty -> DRAIN.
- DRAIN: addr_m/wdata_m = head entry, wr_m=1. On ready_m: head pops, count-1, go to IDLE.
- RD_MEM: addr_m=addr_c, rd_m=1. On ready_m: rdata_c<=rdata_m, go to RESP.
- RESP: ready_c=1 for 1 cycle, then IDLE. ACCEPT behaves the same way.
- An in-flight DRAIN always completes before a newly arrived read is serviced. A read never preempts a started memory access.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty are derived from count, never from pointer equality alone.
- Forwarding compare covers only valid entries. Among multiple matches, the youngest (closest to tail) wins.
- A cache write and a drain pop never occur in the same cycle (single FSM), so count changes by at most 1 per cycle.

Optional Feature:
- Macro WB_COALESCE_EN.
- Defined: a write whose addr_c matches a valid entry overwrites that entry's data in place. count is unchanged and ready_c pulses as in ACCEPT, even when full. The youngest match is overwritten.
- Undefined: every write appends a new entry; duplicates coexist and drain in order.

Test Plan:
- Reset, then write 0x0A3<-0x5C with ready_m tied 1 cycle after strobe -> ready_c 2 cycles after wr_c; count 1 then 0; wr_m seen once with addr 0x0A3, data 0x5C.
- Hold ready_m=0, issue 4 writes (addr 0x010..0x013, data 0x11..0x14) -> full=1, count=4. A 5th write stalls with no ready_c until ready_m releases one drain. Memory then receives writes in order 0x010..0x014.
- With 0x020<-0xAA queued and ready_m=0, read 0x020 -> rdata_c=0xAA with ready_c 2 cycles after rd_c, and no rd_m asserted.
- With writes queued, read miss 0x1FF; memory returns 0x77 -> rd_m is issued before the remaining queued writes drain (after any in-flight drain completes); rdata_c=0x77; queue order preserved.
- Write 0x030<-0x01 then 0x030<-0x02 while ready_m=0, read 0x030 -> 0x02 returned. Count is 2 without WB_COALESCE_EN and 1 with it.
- Assert reset during DRAIN with wr_m high and count=3 -> next cycle wr_m=0, count=0, empty=1, no ready_c.

Source files
------------

// File: rtl/mem_write_buffer_if.sv
// Bus bundle for the posted-write buffer: the cache-side request/response
// and the memory-side strobe/response. The buffer uses the slave view; the
// surrounding logic (cache plus memory) uses the master view.
interface mem_write_buffer_if #(
  parameter int AWIDTH = 9,
  parameter int DWIDTH = 8
);
  logic [AWIDTH-1:0] addr_c;
  logic [DWIDTH-1:0] wdata_c;
  logic              rd_c;
  logic              wr_c;
  logic [DWIDTH-1:0] rdata_c;
  logic              ready_c;

  logic [AWIDTH-1:0] addr_m;
  logic [DWIDTH-1:0] wdata_m;
  logic              rd_m;
  logic              wr_m;
  logic [DWIDTH-1:0] rdata_m;
  logic              ready_m;

  modport slave (
    input  addr_c, wdata_c, rd_c, wr_c, rdata_m, ready_m,
    output rdata_c, ready_c, addr_m, wdata_m, rd_m, wr_m
  );

  modport master (
    output addr_c, wdata_c, rd_c, wr_c, rdata_m, ready_m,
    input  rdata_c, ready_c, addr_m, wdata_m, rd_m, wr_m
  );
endinterface

// File: rtl/mem_write_buffer.sv
// Posted-write buffer between the cache memory-side port and main memory.
// Writes complete to the cache as soon as they are queued and drain to memory
// oldest first. Reads that hit a queued address are forwarded from the buffer
// (youngest match); read misses go to memory ahead of pending writes, but never
// preempt a memory access that has already started.
//
// Optional build macro WB_COALESCE_EN: a write that hits a queued address
// overwrites the youngest matching entry in place instead of appending.
//
// state  | meaning
// IDLE   | arbitrate: read > write > background drain
// ACCEPT | write queued (or merged); pulse ready_c
// DRAIN  | head entry on memory bus with wr_m until ready_m, then pop
// RD_MEM | read miss on memory bus with rd_m until ready_m
// RESP   | read data in rdata_c; pulse ready_c
module mem_write_buffer #(
  parameter int AWIDTH = 9,
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  mem_write_buffer_if.slave      bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {IDLE, ACCEPT, DRAIN, RD_MEM, RESP} state_t;

  state_t            state_q, state_d;

  logic [AWIDTH-1:0] addr_q [DEPTH];
  logic [DWIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PW-1:0]     head_q, tail_q;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, empty_q;

  logic              ready_c_q, ready_c_d;
  logic              rd_m_q, rd_m_d;
  logic              wr_m_q, wr_m_d;
  logic [AWIDTH-1:0] addr_m_q, addr_m_d;
  logic [DWIDTH-1:0] wdata_m_q, wdata_m_d;
  logic [DWIDTH-1:0] rdata_c_q, rdata_c_d;

  logic              hit;
  logic [PW-1:0]     hit_idx;
  logic [PW-1:0]     scan_idx;
  logic              merge_ok;
  logic              push, pop, merge;

  assign bus.ready_c = ready_c_q;
  assign bus.rd_m    = rd_m_q;
  assign bus.wr_m    = wr_m_q;
  assign bus.addr_m  = addr_m_q;
  assign bus.wdata_m = wdata_m_q;
  assign bus.rdata_c = rdata_c_q;
  assign count       = count_q;
  assign full        = full_q;
  assign empty       = empty_q;

`ifdef WB_COALESCE_EN
  assign merge_ok = hit;
`else
  assign merge_ok = 1'b0;
`endif

  // Address search, oldest to youngest, so the last match kept is the youngest.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    scan_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PW'(i);
      if (valid_q[scan_idx] && (addr_q[scan_idx] == bus.addr_c)) begin
        hit     = 1'b1;
        hit_idx = scan_idx;
      end
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d   = state_q;
    ready_c_d = 1'b0;
    rd_m_d    = rd_m_q;
    wr_m_d    = wr_m_q;
    addr_m_d  = addr_m_q;
    wdata_m_d = wdata_m_q;
    rdata_c_d = rdata_c_q;
    push      = 1'b0;
    pop       = 1'b0;
    merge     = 1'b0;
    case (state_q)
      IDLE: begin
        // While ready_c is still high the cache has not yet dropped the
        // request it just completed, so nothing is sampled this cycle.
        if (!ready_c_q) begin
          if (bus.rd_c) begin
            if (hit) begin
              rdata_c_d = data_q[hit_idx];
              state_d   = RESP;
            end else begin
              rd_m_d   = 1'b1;
              addr_m_d = bus.addr_c;
              state_d  = RD_MEM;
            end
          end else if (bus.wr_c && merge_ok) begin
            merge   = 1'b1;
            state_d = ACCEPT;
          end else if (bus.wr_c && !full_q) begin
            push    = 1'b1;
            state_d = ACCEPT;
          end else if (!empty_q) begin
            // Covers both a write blocked by a full queue and idle draining;
            // a blocked write stays on the bus and is taken after the pop.
            wr_m_d    = 1'b1;
            addr_m_d  = addr_q[head_q];
            wdata_m_d = data_q[head_q];
            state_d   = DRAIN;
          end
        end
      end
      ACCEPT: begin
        ready_c_d = 1'b1;
        state_d   = IDLE;
      end
      DRAIN: begin
        if (bus.ready_m) begin
          wr_m_d  = 1'b0;
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      RD_MEM: begin
        if (bus.ready_m) begin
          rd_m_d    = 1'b0;
          rdata_c_d = bus.rdata_m;
          state_d   = RESP;
        end
      end
      RESP: begin
        ready_c_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Occupancy after this cycle's push or pop (never both in one cycle).
  always_comb begin
    count_d = count_q;
    if (push) begin
      count_d = count_q + CW'(1);
    end else if (pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // State, pointers, occupancy flags and all bus outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      head_q    <= '0;
      tail_q    <= '0;
      valid_q   <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ready_c_q <= 1'b0;
      rd_m_q    <= 1'b0;
      wr_m_q    <= 1'b0;
      addr_m_q  <= '0;
      wdata_m_q <= '0;
      rdata_c_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      full_q    <= (count_d == CW'(DEPTH));
      empty_q   <= (count_d == '0);
      ready_c_q <= ready_c_d;
      rd_m_q    <= rd_m_d;
      wr_m_q    <= wr_m_d;
      addr_m_q  <= addr_m_d;
      wdata_m_q <= wdata_m_d;
      rdata_c_q <= rdata_c_d;
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PW'(1);
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
    end
  end

  // Entry storage; contents are qualified by valid_q so need no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      addr_q[tail_q] <= bus.addr_c;
      data_q[tail_q] <= bus.wdata_c;
    end else if (merge) begin
      data_q[hit_idx] <= bus.wdata_c;
    end
  end
endmodule
